async_fifo_core: RTL and testbench
==================================

ASYNC_FIFO_CORE -- requirements
Module: async_fifo_core

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 4, storage depth 2**ADDR_WIDTH words (16).
REQ-003 The block SHALL expose parameter AFULL_THRESH, default 12, w_count level at or above which almost_full asserts.
REQ-004 The block SHALL expose parameter AEMPTY_THRESH, default 4, r_count level at or below which almost_empty asserts.
REQ-005 The block SHALL expose parameter SYNC_STAGES, default 2, flop count of each cross-domain pointer synchronizer (legal range 2..4).
REQ-006 w_clk  input  1  write-domain clock; all w_* outputs are registered on its rising edge.
REQ-007 r_clk  input  1  read-domain clock; all r_* outputs are registered on its rising edge.
REQ-008 arstn  input  1  reset, asynchronous, active-low; clears both domains.
REQ-009 w_en  input  1  write request.
REQ-010 w_data  input  DATA_WIDTH  write data.
REQ-011 full  output  1  no free entry (w_clk domain).
REQ-012 almost_full  output  1  w_count >= AFULL_THRESH.
REQ-013 w_count  output  ADDR_WIDTH+1  occupancy seen by the write side.
REQ-014 overflow  output  1  one-cycle pulse: write rejected.
REQ-015 r_en  input  1  read request.
REQ-016 r_data  output  DATA_WIDTH  registered read data.
REQ-017 r_valid  output  1  one-cycle pulse: r_data holds a newly popped word.
REQ-018 empty  output  1  no readable entry (r_clk domain).
REQ-019 almost_empty  output  1  r_count <= AEMPTY_THRESH.
REQ-020 r_count  output  ADDR_WIDTH+1  occupancy seen by the read side.
REQ-021 underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-022 Write and read pointers SHALL be ADDR_WIDTH+1 bits, kept in binary and Gray form; the MSB is the wrap bit, the low ADDR_WIDTH bits address storage.
REQ-023 Only Gray pointers SHALL cross domains, each through a SYNC_STAGES flop chain clocked by the destination clock.
REQ-024 A write SHALL be accepted on a w_clk edge when w_en=1 and full=0: storage[wptr] <= w_data, wptr increments by 1 modulo 2**(ADDR_WIDTH+1).
REQ-025 w_en=1 with full=1 SHALL leave storage and wptr unchanged and pulse overflow high for exactly that next w_clk cycle.
REQ-026 full SHALL be registered and assert when next write Gray pointer equals synchronized read Gray pointer with its two MSBs inverted.
REQ-027 A read SHALL be accepted on an r_clk edge when r_en=1 and empty=0: r_data <= storage[rptr], r_valid=1 for one cycle, rptr increments; latency r_en to r_data is 1 r_clk cycle.
REQ-028 r_en=1 with empty=1 SHALL hold r_data, keep r_valid=0 and pulse underflow for one r_clk cycle.
REQ-029 empty SHALL be registered and assert when next read Gray pointer equals synchronized write Gray pointer.
REQ-030 w_count SHALL equal wptr minus Gray-to-binary synchronized rptr, modulo 2**(ADDR_WIDTH+1); r_count symmetrically; both registered alongside full/empty.
REQ-031 Flags SHALL be pessimistic: full/almost_full deassert and empty/almost_empty deassert only after the opposite pointer crosses, within SYNC_STAGES+1 destination-clock cycles.
REQ-032 A word written at w_clk edge N SHALL not be readable before SYNC_STAGES+1 r_clk edges after edge N.
REQ-033 Wrap-around SHALL be seamless: continuous traffic past index 2**ADDR_WIDTH-1 returns to 0 with no lost or duplicated word.
REQ-034 Simultaneous write and read in the same period SHALL both complete; a full FIFO reading while writing stays full on the write side until the read pointer syncs.
REQ-035 Storage SHALL be a plain register array with no reset; contents are unreadable until written.

Reset
REQ-036 While arstn=0: pointers and synchronizers 0, full=0, almost_full=0, w_count=0, overflow=0, empty=1, almost_empty=1, r_count=0, r_data=0, r_valid=0, underflow=0.
REQ-037 arstn assertion mid-operation SHALL immediately discard all queued data; first post-reset read returns the first post-reset write.
REQ-038 Reset deassertion SHALL be synchronized externally per clock domain; the block requires arstn high for at least SYNC_STAGES+1 cycles of each clock before first w_en/r_en.

Verification
REQ-039 Defaults, w_clk 10 ns, r_clk 14 ns: write 0x01..0x10 -> full=1 after 16th write, w_count=16, almost_full=1 from w_count=12; 17th write -> overflow pulse, data intact.
REQ-040 Drain full FIFO -> r_data 0x01..0x10 in order, each with one r_valid pulse; empty=1 after 16th read; extra r_en -> underflow pulse, r_data stays 0x10.
REQ-041 Single write 0xA5 into empty FIFO -> empty deasserts no earlier than 3 r_clk edges later; read returns 0xA5 one cycle after r_en.
REQ-042 Streaming 100 words with w_clk 7 ns, r_clk 11 ns, random w_en/r_en -> scoreboard match, no overflow/underflow when flags honoured, pointers wrap cleanly.
REQ-043 Write 5 words, assert arstn=0 for 2 cycles mid-stream -> all outputs at reset values; then write 0x3C, read -> 0x3C.
REQ-044 Parameter sweep DATA_WIDTH=32, ADDR_WIDTH=6, SYNC_STAGES=3 -> full at 64 entries, w_count reaches 64, data integrity preserved.

Source files
------------

// File: rtl/async_fifo_core.sv
// async_fifo_core: dual-clock FIFO with Gray-coded pointer crossing.
// The write side owns storage and the write pointer; the read side owns the
// read pointer and the registered read data. Only Gray pointers cross clock
// domains, so flags are pessimistic until the opposite pointer has synced.
`timescale 1ns/100ps
module async_fifo_core #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  w_clk,
  input  logic                  r_clk,
  input  logic                  arstn,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   w_count,
  output logic                  overflow,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   r_count,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);
  // Inverting the two MSBs of a Gray pointer yields the Gray code of the
  // same address one full lap ahead, which is the full condition.
  localparam logic [PW-1:0] FULL_MASK  = {2'b11, {(PW-2){1'b0}}};

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_WIDTH];

  // write-domain state
  logic [PW-1:0] wbin_r, wgray_r;
  logic [PW-1:0] rgray_sync_r [SYNC_STAGES];
  logic          full_r, afull_r, overflow_r;
  logic [PW-1:0] w_count_r;
  logic          w_inc_s;
  logic [PW-1:0] wbin_next_s, wgray_next_s, rq_s, w_count_next_s;

  // read-domain state
  logic [PW-1:0]         rbin_r, rgray_r;
  logic [PW-1:0]         wgray_sync_r [SYNC_STAGES];
  logic                  empty_r, aempty_r, underflow_r, r_valid_r;
  logic [PW-1:0]         r_count_r;
  logic [DATA_WIDTH-1:0] r_data_r;
  logic                  r_inc_s;
  logic [PW-1:0]         rbin_next_s, rgray_next_s, wq_s, r_count_next_s;

  // Next write pointer, full test and write-side occupancy.
  always_comb begin
    w_inc_s        = w_en & ~full_r;
    wbin_next_s    = wbin_r + PW'(w_inc_s);
    wgray_next_s   = bin2gray(wbin_next_s);
    rq_s           = rgray_sync_r[SYNC_STAGES-1];
    w_count_next_s = wbin_next_s - gray2bin(rq_s);
  end

  // Next read pointer, empty test and read-side occupancy.
  always_comb begin
    r_inc_s        = r_en & ~empty_r;
    rbin_next_s    = rbin_r + PW'(r_inc_s);
    rgray_next_s   = bin2gray(rbin_next_s);
    wq_s           = wgray_sync_r[SYNC_STAGES-1];
    r_count_next_s = gray2bin(wq_s) - rbin_next_s;
  end

  // Storage array: written on accepted writes only, intentionally unreset.
  always_ff @(posedge w_clk) begin
    if (w_inc_s) begin
      mem_r[wbin_r[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

  // Bring the read Gray pointer into the write domain.
  always_ff @(posedge w_clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) rgray_sync_r[i] <= {PW{1'b0}};
    end else begin
      rgray_sync_r[0] <= rgray_r;
      for (int i = 1; i < SYNC_STAGES; i++) rgray_sync_r[i] <= rgray_sync_r[i-1];
    end
  end

  // Write pointer and registered write-side flags.
  always_ff @(posedge w_clk or negedge arstn) begin
    if (!arstn) begin
      wbin_r     <= {PW{1'b0}};
      wgray_r    <= {PW{1'b0}};
      full_r     <= 1'b0;
      afull_r    <= 1'b0;
      w_count_r  <= {PW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      wbin_r     <= wbin_next_s;
      wgray_r    <= wgray_next_s;
      full_r     <= (wgray_next_s == (rq_s ^ FULL_MASK));
      afull_r    <= (w_count_next_s >= AFULL_LVL);
      w_count_r  <= w_count_next_s;
      overflow_r <= w_en & full_r;
    end
  end

  // Bring the write Gray pointer into the read domain.
  always_ff @(posedge r_clk or negedge arstn) begin
    if (!arstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) wgray_sync_r[i] <= {PW{1'b0}};
    end else begin
      wgray_sync_r[0] <= wgray_r;
      for (int i = 1; i < SYNC_STAGES; i++) wgray_sync_r[i] <= wgray_sync_r[i-1];
    end
  end

  // Read pointer, registered read data and read-side flags.
  always_ff @(posedge r_clk or negedge arstn) begin
    if (!arstn) begin
      rbin_r      <= {PW{1'b0}};
      rgray_r     <= {PW{1'b0}};
      empty_r     <= 1'b1;
      aempty_r    <= 1'b1;
      r_count_r   <= {PW{1'b0}};
      underflow_r <= 1'b0;
      r_valid_r   <= 1'b0;
      r_data_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      rbin_r      <= rbin_next_s;
      rgray_r     <= rgray_next_s;
      empty_r     <= (rgray_next_s == wq_s);
      aempty_r    <= (r_count_next_s <= AEMPTY_LVL);
      r_count_r   <= r_count_next_s;
      underflow_r <= r_en & empty_r;
      r_valid_r   <= r_inc_s;
      if (r_inc_s) begin
        r_data_r <= mem_r[rbin_r[ADDR_WIDTH-1:0]];
      end else begin
        r_data_r <= r_data_r;
      end
    end
  end

  assign full         = full_r;
  assign almost_full  = afull_r;
  assign w_count      = w_count_r;
  assign overflow     = overflow_r;
  assign r_data       = r_data_r;
  assign r_valid      = r_valid_r;
  assign empty        = empty_r;
  assign almost_empty = aempty_r;
  assign r_count      = r_count_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_async_fifo_core.sv
// Bench for async_fifo_core: queue-based reference model, scenario tasks.
`timescale 1ns/100ps
module tb_async_fifo_core;

  logic w_clk = 1'b0, r_clk = 1'b0, arstn = 1'b0;
  realtime w_half = 5.0, r_half = 7.0;

  logic       w_en = 1'b0, r_en = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       full, almost_full, overflow, r_valid, empty, almost_empty, underflow;
  logic [4:0] w_count, r_count;
  logic [7:0] r_data;

  logic        w_en2 = 1'b0, r_en2 = 1'b0;
  logic [31:0] w_data2 = 32'h0;
  logic        full2, almost_full2, overflow2, r_valid2, empty2, almost_empty2, underflow2;
  logic [6:0]  w_count2, r_count2;
  logic [31:0] r_data2;

  int checks = 0, errors = 0;
  logic [7:0]  model_q[$];
  logic [31:0] model2_q[$];

  async_fifo_core dut (
    .w_clk(w_clk), .r_clk(r_clk), .arstn(arstn),
    .w_en(w_en), .w_data(w_data), .full(full), .almost_full(almost_full),
    .w_count(w_count), .overflow(overflow),
    .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .empty(empty),
    .almost_empty(almost_empty), .r_count(r_count), .underflow(underflow)
  );

  async_fifo_core #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .AFULL_THRESH(48),
                    .AEMPTY_THRESH(16), .SYNC_STAGES(3)) dut2 (
    .w_clk(w_clk), .r_clk(r_clk), .arstn(arstn),
    .w_en(w_en2), .w_data(w_data2), .full(full2), .almost_full(almost_full2),
    .w_count(w_count2), .overflow(overflow2),
    .r_en(r_en2), .r_data(r_data2), .r_valid(r_valid2), .empty(empty2),
    .almost_empty(almost_empty2), .r_count(r_count2), .underflow(underflow2)
  );

  initial forever #(w_half) w_clk = ~w_clk;
  initial begin
    #1;
    forever #(r_half) r_clk = ~r_clk;
  end

  task automatic apply_reset();
    w_en = 1'b0; r_en = 1'b0; w_en2 = 1'b0; r_en2 = 1'b0;
    arstn = 1'b0;
    repeat (2) @(negedge w_clk);
    arstn = 1'b1;
    repeat (5) @(negedge w_clk);
    repeat (5) @(negedge r_clk);
    model_q.delete();
    model2_q.delete();
  endtask

  task automatic do_write(input logic [7:0] d);
    @(negedge w_clk);
    w_en = 1'b1; w_data = d;
    @(negedge w_clk);
    w_en = 1'b0;
  endtask

  task automatic do_read();
    @(negedge r_clk);
    r_en = 1'b1;
    @(negedge r_clk);
    r_en = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0; w_en = 1'b1; r_en = 1'b1; w_data = 8'h5A;
    repeat (3) @(negedge w_clk);
    checks++;
    if ({full, almost_full, w_count, overflow} !== 8'b0) begin
      errors++;
      $display("FAIL reset_wside: full=%b afull=%b w_count=%0d ovf=%b, expected 0 0 0 0",
               full, almost_full, w_count, overflow);
    end
    checks++;
    if ({empty, almost_empty, r_count, r_data, r_valid, underflow} !== {2'b11, 5'd0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_rside: empty=%b aempty=%b r_count=%0d r_data=%h rv=%b unf=%b, expected 1 1 0 00 0 0",
               empty, almost_empty, r_count, r_data, r_valid, underflow);
    end
    w_en = 1'b0; r_en = 1'b0;
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      do_write(8'(i));
      model_q.push_back(8'(i));
      checks++;
      if (w_count !== 5'(i) || almost_full !== (i >= 12) || full !== (i == 16)) begin
        errors++;
        $display("FAIL fill_level: write %0d w_count=%0d afull=%b full=%b, expected %0d %b %b",
                 i, w_count, almost_full, full, i, (i >= 12), (i == 16));
      end
    end
    @(negedge w_clk);
    w_en = 1'b1; w_data = 8'hEE;
    @(negedge w_clk);
    w_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || w_count !== 5'd16 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse: ovf=%b w_count=%0d full=%b, expected 1 16 1", overflow, w_count, full);
    end
    @(negedge w_clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_width: ovf=%b, expected 0", overflow);
    end
    repeat (5) @(negedge r_clk);
    checks++;
    if (r_count !== 5'd16 || empty !== 1'b0 || almost_empty !== 1'b0) begin
      errors++;
      $display("FAIL rside_full: r_count=%0d empty=%b aempty=%b, expected 16 0 0", r_count, empty, almost_empty);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 1; i <= 16; i++) begin
      @(negedge r_clk);
      checks++;
      if (r_valid !== 1'b0) begin
        errors++;
        $display("FAIL rvalid_width: read %0d r_valid=%b, expected 0", i, r_valid);
      end
      r_en = 1'b1;
      @(negedge r_clk);
      r_en = 1'b0;
      exp = model_q.pop_front();
      checks++;
      if (r_valid !== 1'b1 || r_data !== exp || empty !== (i == 16) || almost_empty !== ((16 - i) <= 4)) begin
        errors++;
        $display("FAIL drain: read %0d rv=%b data=%h empty=%b aempty=%b, expected 1 %h %b %b",
                 i, r_valid, r_data, empty, almost_empty, exp, (i == 16), ((16 - i) <= 4));
      end
    end
    do_read();
    checks++;
    if (underflow !== 1'b1 || r_valid !== 1'b0 || r_data !== 8'h10) begin
      errors++;
      $display("FAIL underflow: unf=%b rv=%b data=%h, expected 1 0 10", underflow, r_valid, r_data);
    end
    @(negedge r_clk);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_width: unf=%b, expected 0", underflow);
    end
    repeat (6) @(negedge w_clk);
    checks++;
    if (full !== 1'b0 || almost_full !== 1'b0 || w_count !== 5'd0) begin
      errors++;
      $display("FAIL wside_drained: full=%b afull=%b w_count=%0d, expected 0 0 0", full, almost_full, w_count);
    end
  endtask

  task automatic test_latency();
    int cnt = 0;
    apply_reset();
    @(negedge w_clk);
    w_en = 1'b1; w_data = 8'hA5;
    @(posedge w_clk);
    fork
      begin
        @(negedge w_clk);
        w_en = 1'b0;
      end
    join_none
    while (empty === 1'b1 && cnt < 20) begin
      @(posedge r_clk);
      cnt++;
      #0.5;
    end
    checks++;
    if (empty !== 1'b0 || cnt < 3 || cnt > 5) begin
      errors++;
      $display("FAIL empty_latency: empty=%b after %0d r_clk edges, expected 0 within 3..5", empty, cnt);
    end
    do_read();
    checks++;
    if (r_valid !== 1'b1 || r_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_word: rv=%b data=%h, expected 1 a5", r_valid, r_data);
    end
  endtask

  task automatic test_stream();
    int wr = 0, rd = 0;
    w_half = 3.5; r_half = 5.5;
    apply_reset();
    fork
      begin
        for (int cyc = 0; cyc < 4000 && wr < 100; cyc++) begin
          @(negedge w_clk);
          checks++;
          if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_overflow: ovf=%b at write %0d, expected 0", overflow, wr);
          end
          if (!full && $urandom_range(0, 1) == 1) begin
            w_en = 1'b1; w_data = 8'($urandom);
            model_q.push_back(w_data);
            wr++;
          end else begin
            w_en = 1'b0;
          end
        end
        @(negedge w_clk);
        w_en = 1'b0;
      end
      begin
        logic [7:0] exp;
        for (int cyc = 0; cyc < 8000 && rd < 100; cyc++) begin
          @(negedge r_clk);
          if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL stream_underflow: unf=%b at read %0d, expected 0", underflow, rd);
          end
          if (r_valid === 1'b1) begin
            checks++;
            if (model_q.size() == 0) begin
              errors++;
              $display("FAIL stream_extra: word %h popped with model empty, expected none", r_data);
            end else begin
              exp = model_q.pop_front();
              if (r_data !== exp) begin
                errors++;
                $display("FAIL stream_data: read %0d got %h, expected %h", rd, r_data, exp);
              end
            end
            rd++;
          end
          r_en = (!empty && $urandom_range(0, 1) == 1);
        end
        r_en = 1'b0;
      end
    join
    repeat (6) @(negedge w_clk);
    repeat (6) @(negedge r_clk);
    checks++;
    if (wr != 100 || rd != 100 || w_count !== 5'd0 || r_count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: wr=%0d rd=%0d w_count=%0d r_count=%0d empty=%b full=%b, expected 100 100 0 0 1 0",
               wr, rd, w_count, r_count, empty, full);
    end
    w_half = 5.0; r_half = 7.0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 5; i++) do_write(8'(8'h20 + i));
    repeat (4) @(negedge r_clk);
    @(negedge w_clk);
    arstn = 1'b0;
    #1;
    checks++;
    if ({full, almost_full, w_count, overflow, empty, almost_empty, r_count, r_data, r_valid, underflow}
        !== {3'b000, 5'd0, 2'b11, 5'd0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid: full=%b afull=%b wc=%0d ovf=%b empty=%b aempty=%b rc=%0d data=%h rv=%b unf=%b, expected reset values",
               full, almost_full, w_count, overflow, empty, almost_empty, r_count, r_data, r_valid, underflow);
    end
    repeat (2) @(negedge w_clk);
    arstn = 1'b1;
    repeat (5) @(negedge w_clk);
    repeat (5) @(negedge r_clk);
    do_write(8'h3C);
    for (int k = 0; k < 20 && empty === 1'b1; k++) @(negedge r_clk);
    checks++;
    if (empty !== 1'b0 || r_count !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_level: empty=%b r_count=%0d, expected 0 1", empty, r_count);
    end
    do_read();
    checks++;
    if (r_valid !== 1'b1 || r_data !== 8'h3C || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_word: rv=%b data=%h empty=%b, expected 1 3c 1", r_valid, r_data, empty);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    apply_reset();
    for (int i = 1; i <= 64; i++) begin
      @(negedge w_clk);
      w_en2 = 1'b1; w_data2 = $urandom;
      model2_q.push_back(w_data2);
      @(negedge w_clk);
      w_en2 = 1'b0;
      checks++;
      if (w_count2 !== 7'(i) || full2 !== (i == 64)) begin
        errors++;
        $display("FAIL sweep_fill: write %0d w_count=%0d full=%b, expected %0d %b", i, w_count2, full2, i, (i == 64));
      end
    end
    repeat (6) @(negedge r_clk);
    for (int i = 1; i <= 64; i++) begin
      @(negedge r_clk);
      r_en2 = 1'b1;
      @(negedge r_clk);
      r_en2 = 1'b0;
      exp = model2_q.pop_front();
      checks++;
      if (r_valid2 !== 1'b1 || r_data2 !== exp) begin
        errors++;
        $display("FAIL sweep_data: read %0d rv=%b data=%h, expected 1 %h", i, r_valid2, r_data2, exp);
      end
    end
    checks++;
    if (empty2 !== 1'b1) begin
      errors++;
      $display("FAIL sweep_empty: empty=%b, expected 1", empty2);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_stream();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
